pll_reset_seq: RTL and testbench
================================

// Module: pll_reset_seq
// PURPOSE
//  Sequences the iCE40 SB_PLL40_CORE wrapper: drives the PLL RESETB and qualifies LOCK.
//  Releases a system reset only after lock has been continuously stable; recovers on loss of lock.
//  Runs on the 48 MHz reference clock (the PLL input), so it works while the PLL is unlocked.
//  Sits between the board clock pin, the pll wrapper, and the per-domain reset synchronisers.
// PARAMETERS
//  RESET_CYCLES   48     cycles RESETB is held low per attempt (1 us @ 48 MHz)
//  LOCK_TIMEOUT   4800   cycles to wait for LOCK before retrying (100 us)
//  STABLE_CYCLES  480    cycles LOCK must stay high before release (10 us)
//  MAX_RETRIES    4      consecutive lock timeouts before FAULT (>=1)
//  CNT_W          16     shared cycle-counter width; must hold max of the three cycle counts
// PORTS
//  clock_in         in   1  48 MHz reference clock (same net as PLL REFERENCECLK)
//  resetn           in   1  synchronous reset, active low
//  locked           in   1  raw PLL LOCK, asynchronous to clock_in
//  relock_req       in   1  single-cycle request to force a full PLL re-lock
//  pll_resetb       out  1  to PLL RESETB; 0 = PLL held in reset
//  sys_resetn       out  1  system reset, active low; downstream resyncs per clock domain
//  ready            out  1  1 while in RUN
//  fault            out  1  1 while in FAULT
//  state            out  3  current state code, for debug/LED
//  lock_loss_count  out  8  count of unrequested RUN lock losses, saturates at 255
// BEHAVIOUR
//  - Reset (resetn=0 at an edge): state=RESET_PLL, cnt=0, retry=0, pll_resetb=0, sys_resetn=0,
//    ready=0, fault=0, lock_loss_count=0, both sync flops=0. Mid-operation reset aborts any state.
//  - locked passes through a 2-flop synchroniser -> locked_s (2-cycle latency). FSM uses only locked_s.
//  - All outputs are registered, decoded from next_state; they change on the edge the state changes.
//  - State codes: RESET_PLL=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAULT=4.
//  - RESET_PLL: pll_resetb=0. cnt counts 0..RESET_CYCLES-1; at RESET_CYCLES-1 -> WAIT_LOCK, cnt=0.
//  - WAIT_LOCK: pll_resetb=1. locked_s=1 -> STABLE, cnt=0. Else at cnt==LOCK_TIMEOUT-1: if
//    retry==MAX_RETRIES-1 -> FAULT, else retry+=1 and -> RESET_PLL, cnt=0.
//  - STABLE: pll_resetb=1. locked_s=0 -> WAIT_LOCK, cnt=0 (glitch; retry unchanged, timeout restarts).
//    At cnt==STABLE_CYCLES-1 with locked_s=1 -> RUN, retry=0.
//  - RUN: pll_resetb=1, sys_resetn=1, ready=1. locked_s=0 -> RESET_PLL, cnt=0,
//    lock_loss_count+=1 (saturating at 255).
//  - FAULT: pll_resetb=0, fault=1, sys_resetn=0. Leaves only via relock_req or resetn.
//  - relock_req=1 in any state has top priority: -> RESET_PLL, cnt=0, retry=0, no count increment.
//    This holds even if locked_s falls in RUN on the same cycle. In RESET_PLL it restarts the hold.
//  - sys_resetn is 0 in every state except RUN. ready == sys_resetn at all times.
//  - Counters never wrap. cnt is cleared on every state change.
//  - Raw LOCK fall in RUN -> sys_resetn low 3 edges later (2 sync + 1 FSM).
// STRUCTURE
//  - Shared header pll_reset_defs.vh: state code localparams (3-bit) and the STATE_W width.
//    The debug/LED decoder uses the same header.
//  - One sub-module: sync_2ff (single-bit 2-flop synchroniser, sync active-low reset).
//    It is reused for other async inputs.
//  - Top holds one shared CNT_W counter, a retry counter of width clog2(MAX_RETRIES)+1,
//    the FSM, and the output registers.
// TESTING (bench params: RESET_CYCLES=4, LOCK_TIMEOUT=16, STABLE_CYCLES=8, MAX_RETRIES=2)
//  1 Nominal: resetn released, locked rises 2 cycles into WAIT_LOCK and stays high ->
//    pll_resetb=0 for exactly 4 cycles, STABLE 3 cycles after locked rise, sys_resetn=ready=1
//    after 8 more cycles, state=3.
//  2 Lock glitch: locked high 5 cycles, low 1, then high -> STABLE->WAIT_LOCK->STABLE.
//    Release is 8 cycles after re-entry. retry stays 0 and pll_resetb is never pulsed.
//  3 Timeout/fault: locked held 0 -> WAIT_LOCK 16 cycles, RESET_PLL 4, WAIT_LOCK 16 -> FAULT.
//    fault=1, pll_resetb=0. Then relock_req with locked rising -> reaches RUN, fault=0.
//  4 Loss in RUN: drop locked -> sys_resetn=0 on the 3rd edge, lock_loss_count 0->1,
//    pll_resetb low 4 cycles. Repeat 256 times -> count holds at 255.
//  5 Simultaneous: in RUN, relock_req pulses on the same cycle locked_s falls ->
//    RESET_PLL, lock_loss_count unchanged.
//  6 Reset mid-op: resetn=0 in STABLE and in FAULT -> next edge: all outputs at reset values,
//    state=0, lock_loss_count=0.

Source files
------------

// File: rtl/pll_reset_seq_pkg.sv
// Shared state codes and widths for the PLL reset sequencer and its debug/LED decoder.
package pll_reset_seq_pkg;

    localparam int STATE_W = 3;
    localparam int LLC_W   = 8;

    localparam logic [STATE_W-1:0] ST_RESET_PLL = 3'd0;
    localparam logic [STATE_W-1:0] ST_WAIT_LOCK = 3'd1;
    localparam logic [STATE_W-1:0] ST_STABLE    = 3'd2;
    localparam logic [STATE_W-1:0] ST_RUN       = 3'd3;
    localparam logic [STATE_W-1:0] ST_FAULT     = 3'd4;

    // PLL is released from reset while waiting for, qualifying, or using lock.
    function automatic logic pll_released(input logic [STATE_W-1:0] st);
        return (st == ST_WAIT_LOCK) || (st == ST_STABLE) || (st == ST_RUN);
    endfunction

endpackage

// File: rtl/pll_reset_seq_sync_2ff.sv
// Single-bit two-flop synchroniser with synchronous active-low reset.
module sync_2ff (
    input  logic clock_in,
    input  logic resetn,
    input  logic d,
    output logic q
);

    logic s1_q;
    logic s2_q;

    always_ff @(posedge clock_in) begin
        if (!resetn) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= d;
            s2_q <= s1_q;
        end
    end

    assign q = s2_q;

endmodule

// File: rtl/pll_reset_seq.sv
// Drives PLL RESETB, qualifies a synchronised LOCK and releases the system reset once lock is stable.
//  state     | meaning
//  RESET_PLL | PLL held in reset for RESET_CYCLES
//  WAIT_LOCK | PLL running, waiting up to LOCK_TIMEOUT for lock
//  STABLE    | lock seen, must persist STABLE_CYCLES
//  RUN       | system reset released
//  FAULT     | MAX_RETRIES timeouts; waits for relock_req or resetn
module pll_reset_seq
    import pll_reset_seq_pkg::*;
#(
    parameter int RESET_CYCLES  = 48,
    parameter int LOCK_TIMEOUT  = 4800,
    parameter int STABLE_CYCLES = 480,
    parameter int MAX_RETRIES   = 4,
    parameter int CNT_W         = 16
) (
    input  logic               clock_in,
    input  logic               resetn,
    input  logic               locked,
    input  logic               relock_req,
    output logic               pll_resetb,
    output logic               sys_resetn,
    output logic               ready,
    output logic               fault,
    output logic [STATE_W-1:0] state,
    output logic [LLC_W-1:0]   lock_loss_count
);

    localparam int RETRY_W = $clog2(MAX_RETRIES) + 1;

    logic                 locked_s;
    logic [STATE_W-1:0]   state_q,      state_d;
    logic [CNT_W-1:0]     cnt_q,        cnt_d;
    logic [RETRY_W-1:0]   retry_q,      retry_d;
    logic [LLC_W-1:0]     llc_q,        llc_d;
    logic                 pll_resetb_q, pll_resetb_d;
    logic                 sys_resetn_q, sys_resetn_d;
    logic                 fault_q,      fault_d;

    sync_2ff u_lock_sync (
        .clock_in (clock_in),
        .resetn   (resetn),
        .d        (locked),
        .q        (locked_s)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        retry_d = retry_q;
        llc_d   = llc_q;
        if (relock_req) begin
            state_d = ST_RESET_PLL;
            cnt_d   = '0;
            retry_d = '0;
        end else begin
            case (state_q)
                ST_RESET_PLL: begin
                    if (cnt_q == CNT_W'(RESET_CYCLES - 1)) begin
                        state_d = ST_WAIT_LOCK;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (locked_s) begin
                        state_d = ST_STABLE;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
                        cnt_d = '0;
                        if (retry_q == RETRY_W'(MAX_RETRIES - 1)) begin
                            state_d = ST_FAULT;
                        end else begin
                            state_d = ST_RESET_PLL;
                            retry_d = retry_q + 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_STABLE: begin
                    // A dropout restarts the lock wait without consuming a retry.
                    if (!locked_s) begin
                        state_d = ST_WAIT_LOCK;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_W'(STABLE_CYCLES - 1)) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                        retry_d = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!locked_s) begin
                        state_d = ST_RESET_PLL;
                        cnt_d   = '0;
                        llc_d   = (llc_q == '1) ? llc_q : llc_q + 1'b1;
                    end
                end
                ST_FAULT: begin
                    state_d = ST_FAULT;
                end
                default: begin
                    state_d = ST_RESET_PLL;
                    cnt_d   = '0;
                    retry_d = '0;
                end
            endcase
        end
    end

    always_comb begin
        pll_resetb_d = pll_released(state_d);
        sys_resetn_d = (state_d == ST_RUN);
        fault_d      = (state_d == ST_FAULT);
    end

    always_ff @(posedge clock_in) begin
        if (!resetn) begin
            state_q      <= ST_RESET_PLL;
            cnt_q        <= '0;
            retry_q      <= '0;
            llc_q        <= '0;
            pll_resetb_q <= 1'b0;
            sys_resetn_q <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            retry_q      <= retry_d;
            llc_q        <= llc_d;
            pll_resetb_q <= pll_resetb_d;
            sys_resetn_q <= sys_resetn_d;
            fault_q      <= fault_d;
        end
    end

    assign pll_resetb      = pll_resetb_q;
    assign sys_resetn      = sys_resetn_q;
    assign ready           = sys_resetn_q;
    assign fault           = fault_q;
    assign state           = state_q;
    assign lock_loss_count = llc_q;

endmodule

// File: tb/tb_pll_reset_seq.sv
// Directed vector bench for pll_reset_seq with short cycle parameters.
module tb_pll_reset_seq;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       locked = 1'b0;
    logic       relock_req = 1'b0;
    logic       pll_resetb;
    logic       sys_resetn;
    logic       ready;
    logic       fault;
    logic [2:0] state;
    logic [7:0] lock_loss_count;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pll_reset_seq #(
        .RESET_CYCLES  (4),
        .LOCK_TIMEOUT  (16),
        .STABLE_CYCLES (8),
        .MAX_RETRIES   (2),
        .CNT_W         (16)
    ) dut (
        .clock_in        (clk),
        .resetn          (resetn),
        .locked          (locked),
        .relock_req      (relock_req),
        .pll_resetb      (pll_resetb),
        .sys_resetn      (sys_resetn),
        .ready           (ready),
        .fault           (fault),
        .state           (state),
        .lock_loss_count (lock_loss_count)
    );

    typedef struct {
        logic       rstn;
        logic       lck;
        logic       rlq;
        int         n;
        logic [2:0] st;
        logic [7:0] llc;
    } vec_t;

    vec_t vt[$];

    function automatic void add(input logic rstn, input logic lck, input logic rlq,
                                input int n, input logic [2:0] st, input logic [7:0] llc);
        vec_t v;
        v.rstn = rstn; v.lck = lck; v.rlq = rlq; v.n = n; v.st = st; v.llc = llc;
        vt.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input logic [2:0] st, input logic [7:0] llc);
        check({tag, " state"}, 32'(state), 32'(st));
        check({tag, " pll_resetb"}, 32'(pll_resetb), 32'(st == 3'd1 || st == 3'd2 || st == 3'd3));
        check({tag, " sys_resetn"}, 32'(sys_resetn), 32'(st == 3'd3));
        check({tag, " ready"}, 32'(ready), 32'(st == 3'd3));
        check({tag, " fault"}, 32'(fault), 32'(st == 3'd4));
        check({tag, " lock_loss_count"}, 32'(lock_loss_count), 32'(llc));
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        // reset
        add(0,0,0, 2, 0,0);
        // nominal bring-up, lock rises 2 cycles into WAIT_LOCK
        add(1,0,0, 3, 0,0); add(1,0,0, 1, 1,0); add(1,0,0, 2, 1,0);
        add(1,1,0, 2, 1,0); add(1,1,0, 1, 2,0); add(1,1,0, 7, 2,0); add(1,1,0, 1, 3,0);
        // lock loss in RUN and recovery
        add(1,0,0, 2, 3,0); add(1,0,0, 1, 0,1); add(1,1,0, 3, 0,1); add(1,1,0, 1, 1,1);
        add(1,1,0, 1, 2,1); add(1,1,0, 7, 2,1); add(1,1,0, 1, 3,1);
        // relock request from RUN, into STABLE
        add(1,1,1, 1, 0,1); add(1,1,0, 3, 0,1); add(1,1,0, 1, 1,1); add(1,1,0, 1, 2,1);
        // one-cycle lock glitch in STABLE
        add(1,1,0, 3, 2,1); add(1,0,0, 1, 2,1); add(1,1,0, 1, 2,1); add(1,1,0, 1, 1,1);
        add(1,1,0, 1, 2,1); add(1,1,0, 7, 2,1); add(1,1,0, 1, 3,1);
        // relock on the same edge that locked_s falls in RUN
        add(1,0,0, 2, 3,1); add(1,0,1, 1, 0,1);
        // two timeouts into FAULT, then relock
        add(1,0,0, 3, 0,1); add(1,0,0, 1, 1,1); add(1,0,0,15, 1,1); add(1,0,0, 1, 0,1);
        add(1,0,0, 3, 0,1); add(1,0,0, 1, 1,1); add(1,0,0,15, 1,1); add(1,0,0, 1, 4,1);
        add(1,0,0, 5, 4,1);
        add(1,1,1, 1, 0,1); add(1,1,0, 3, 0,1); add(1,1,0, 1, 1,1); add(1,1,0, 1, 2,1);
        add(1,1,0, 7, 2,1); add(1,1,0, 1, 3,1);
        // reset in STABLE, then reset in FAULT
        add(1,1,1, 1, 0,1); add(1,1,0, 4, 1,1); add(1,1,0, 1, 2,1); add(0,0,0, 1, 0,0);
        add(1,0,0, 4, 1,0); add(1,0,0,16, 0,0); add(1,0,0, 4, 1,0); add(1,0,0,16, 4,0);
        add(0,0,0, 1, 0,0);

        @(negedge clk);
        for (int i = 0; i < vt.size(); i++) begin
            resetn     = vt[i].rstn;
            locked     = vt[i].lck;
            relock_req = vt[i].rlq;
            tick(vt[i].n);
            check_outputs($sformatf("vec%0d", i), vt[i].st, vt[i].llc);
        end

        // bring up to RUN, then 256 lock losses to saturate the counter
        resetn = 1'b1; locked = 1'b1; relock_req = 1'b0;
        tick(13);
        check_outputs("sat bringup", 3'd3, 8'd0);
        for (int i = 0; i < 256; i++) begin
            int low_cnt;
            locked = 1'b0;
            tick(2);
            check($sformatf("loss%0d sys_resetn before 3rd edge", i), 32'(sys_resetn), 32'd1);
            tick(1);
            check_outputs($sformatf("loss%0d", i), 3'd0, (i >= 254) ? 8'd255 : 8'(i + 1));
            locked = 1'b1;
            low_cnt = 0;
            for (int k = 0; k < 20 && pll_resetb == 1'b0; k++) begin
                low_cnt++;
                tick(1);
            end
            check($sformatf("loss%0d pll_resetb low cycles", i), 32'(low_cnt), 32'd4);
            tick(9);
            check($sformatf("loss%0d back in RUN", i), 32'(state), 32'd3);
        end
        check("final saturated count", 32'(lock_loss_count), 32'd255);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
